// File: rtl/ram_matrix_writer_pkg.sv
// Shared sequencer instruction package: opcode values, FSM state encoding and
// the instruction word layout used by the sequencer peripherals.
package ram_matrix_writer_pkg;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_LDR    = 4'd1;
   localparam logic [3:0] OP_LDC    = 4'd2;
   localparam logic [3:0] OP_WR     = 4'd3;
   localparam logic [3:0] OP_FILL   = 4'd4;
   localparam logic [3:0] OP_RD     = 4'd5;
   localparam logic [3:0] OP_CLRERR = 4'd6;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_READ_WAIT = 2'd1;
   localparam logic [1:0] ST_FILL      = 2'd2;

   typedef struct packed {
      logic [3:0] opcode;
      logic [7:0] imm;
   } inst_t;

   function automatic inst_t decode_inst(input logic [11:0] raw);
      return inst_t'(raw);
   endfunction

endpackage

// File: rtl/ram_matrix_writer_matrix_cursor.sv
// Row/column position register with raster-order advance and wrap, plus the
// linear RAM address of the current cell.
module matrix_cursor #(
   parameter int RAMRows = 128,
   parameter int RAMCols = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_row,
   input  logic        load_col,
   input  logic [7:0]  load_value,
   input  logic        advance,
   output logic [15:0] addr,
   output logic        at_end
);

   localparam logic [7:0] LAST_ROW = 8'(RAMRows - 1);
   localparam logic [7:0] LAST_COL = 8'(RAMCols - 1);

   logic [7:0] row_q;
   logic [7:0] col_q;

   // Loads and advance never coincide; advance walks columns first, then rows.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         row_q <= 8'd0;
         col_q <= 8'd0;
      end else begin
         if (load_row) begin
            row_q <= load_value;
         end
         if (load_col) begin
            col_q <= load_value;
         end
         if (advance) begin
            if (col_q == LAST_COL) begin
               col_q <= 8'd0;
               row_q <= (row_q == LAST_ROW) ? 8'd0 : row_q + 8'd1;
            end else begin
               col_q <= col_q + 8'd1;
            end
         end
      end
   end

   assign addr   = 16'(row_q) * 16'(RAMCols) + 16'(col_q);
   assign at_end = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/ram_matrix_writer.sv
// Instruction-driven writer/reader for an external matrix RAM: positions a
// cursor, writes single cells, fills to the end of the matrix, reads back.
module ram_matrix_writer
   import ram_matrix_writer_pkg::*;
#(
   parameter int RAMRows     = 128,
   parameter int RAMCols     = 128,
   parameter int RAMDataSize = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [11:0]            inst,
   input  logic                   inst_en,
   output logic [7:0]             out,
   output logic [15:0]            ram_addr,
   output logic                   ram_we,
   output logic [RAMDataSize-1:0] ram_data_i,
   input  logic [RAMDataSize-1:0] ram_data_o
);

   localparam logic [8:0] ROW_LIM = 9'(RAMRows);
   localparam logic [8:0] COL_LIM = 9'(RAMCols);

   logic [1:0]             state_q;
   logic                   error_q;
   logic                   last_q;
   logic [RAMDataSize-1:0] rd_data_q;
   logic [RAMDataSize-1:0] fill_data_q;

   inst_t       cur;
   logic        busy;
   logic        accept;
   logic        row_ok;
   logic        col_ok;
   logic        load_row;
   logic        load_col;
   logic        advance;
   logic [15:0] cur_addr;
   logic        at_end;

   assign cur    = decode_inst(inst);
   assign busy   = (state_q != ST_IDLE);
   assign accept = inst_en && !busy;
   assign row_ok = ({1'b0, cur.imm} < ROW_LIM);
   assign col_ok = ({1'b0, cur.imm} < COL_LIM);

   // The cursor moves on every committed write and on read completion, except
   // after the final fill write where it has already wrapped to (0,0).
   always_comb begin
      load_row = accept && (cur.opcode == OP_LDR) && row_ok;
      load_col = accept && (cur.opcode == OP_LDC) && col_ok;
      advance  = (accept && ((cur.opcode == OP_WR) || (cur.opcode == OP_FILL)))
               || (state_q == ST_READ_WAIT)
               || ((state_q == ST_FILL) && !last_q);
   end

   matrix_cursor #(
      .RAMRows (RAMRows),
      .RAMCols (RAMCols)
   ) u_cursor (
      .clock      (clock),
      .reset      (reset),
      .load_row   (load_row),
      .load_col   (load_col),
      .load_value (cur.imm),
      .advance    (advance),
      .addr       (cur_addr),
      .at_end     (at_end)
   );

   // RAM strobes are registered: an accepted WR/FILL/RD shows on the bus in the
   // following cycle. last_q remembers that the cell just presented is the final one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         error_q     <= 1'b0;
         last_q      <= 1'b0;
         rd_data_q   <= '0;
         fill_data_q <= '0;
         ram_we      <= 1'b0;
         ram_addr    <= 16'd0;
         ram_data_i  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ram_we <= 1'b0;
               if (inst_en) begin
                  case (cur.opcode)
                     OP_NOP: ;
                     OP_LDR: if (!row_ok) error_q <= 1'b1;
                     OP_LDC: if (!col_ok) error_q <= 1'b1;
                     OP_WR: begin
                        ram_we     <= 1'b1;
                        ram_addr   <= cur_addr;
                        ram_data_i <= cur.imm[RAMDataSize-1:0];
                     end
                     OP_FILL: begin
                        ram_we      <= 1'b1;
                        ram_addr    <= cur_addr;
                        ram_data_i  <= cur.imm[RAMDataSize-1:0];
                        fill_data_q <= cur.imm[RAMDataSize-1:0];
                        last_q      <= at_end;
                        state_q     <= ST_FILL;
                     end
                     OP_RD: begin
                        ram_addr <= cur_addr;
                        state_q  <= ST_READ_WAIT;
                     end
                     OP_CLRERR: error_q <= 1'b0;
                     default: error_q <= 1'b1;
                  endcase
               end
            end
            ST_READ_WAIT: begin
               ram_we    <= 1'b0;
               rd_data_q <= ram_data_o;
               state_q   <= ST_IDLE;
               if (inst_en) error_q <= 1'b1;
            end
            ST_FILL: begin
               if (inst_en) error_q <= 1'b1;
               if (last_q) begin
                  ram_we  <= 1'b0;
                  last_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  ram_we     <= 1'b1;
                  ram_addr   <= cur_addr;
                  ram_data_i <= fill_data_q;
                  last_q     <= at_end;
               end
            end
            default: begin
               ram_we  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // While waiting on a read the low bits show the RAM data as it arrives.
   always_comb begin
      out    = 8'h00;
      out[7] = busy;
      out[6] = error_q;
      out[RAMDataSize-1:0] = (state_q == ST_READ_WAIT) ? ram_data_o : rd_data_q;
   end

endmodule

// File: doc/ram_matrix_writer.md
RAM_MATRIX_WRITER -- requirements
Module: ram_matrix_writer

Interface
REQ-001 SHALL have parameter RAMRows, default 128, number of matrix rows (2..256).
REQ-002 SHALL have parameter RAMCols, default 128, number of matrix columns (2..256).
REQ-003 SHALL have parameter RAMDataSize, default 4, cell width in bits (1..6).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port inst  input  12  instruction; inst[11:8] opcode, inst[7:0] immediate.
REQ-007 SHALL have port inst_en  input  1  inst valid this cycle.
REQ-008 SHALL have port out  output  8  status/readback: [7] busy, [6] error, [5:RAMDataSize] zero, [RAMDataSize-1:0] last read data.
REQ-009 SHALL have port ram_addr  output  16  external RAM address = row*RAMCols+col.
REQ-010 SHALL have port ram_we  output  1  external RAM write strobe.
REQ-011 SHALL have port ram_data_i  output  RAMDataSize  write data to RAM.
REQ-012 SHALL have port ram_data_o  input  RAMDataSize  read data from RAM, valid one cycle after ram_addr presented.

Function
REQ-013 SHALL decode opcodes: 0 NOP, 1 LDR, 2 LDC, 3 WR, 4 FILL, 5 RD, 6 CLRERR; 7-15 set error, no other effect.
REQ-014 LDR SHALL load row<=imm; LDC SHALL load col<=imm; imm>=RAMRows (resp. RAMCols) SHALL leave the register unchanged and set error.
REQ-015 WR SHALL, in the cycle after accept, drive ram_addr=(row,col), ram_data_i=imm[RAMDataSize-1:0], ram_we=1 for exactly one cycle, then advance position.
REQ-016 Advance: col+1; col==RAMCols-1 wraps to 0 with row+1; row==RAMRows-1 with col wrap SHALL wrap to (0,0).
REQ-017 RD SHALL drive ram_addr=(row,col), ram_we=0 in cycle after accept (state READ_WAIT, busy=1); the next cycle SHALL capture ram_data_o into out[RAMDataSize-1:0], advance position, return to IDLE.
REQ-018 FILL SHALL enter state FILL, write imm to each cell from current position through (RAMRows-1,RAMCols-1), one write per cycle with ram_we=1, then return to IDLE with position (0,0).
REQ-019 States SHALL be IDLE, READ_WAIT, FILL; busy=1 in every state except IDLE.
REQ-020 inst_en=1 while busy SHALL drop the instruction and set error; inst_en=1 on the cycle the block returns to IDLE SHALL be accepted.
REQ-021 CLRERR SHALL clear error; error otherwise sticky.
REQ-022 inst_en=0 SHALL cause no state change; ram_we SHALL be 0 in every cycle not listed in REQ-015/018.

Reset
REQ-023 Reset low SHALL immediately force: state IDLE, row=0, col=0, error=0, read data=0, out=8'h00, ram_we=0, ram_addr=0, ram_data_i=0.
REQ-024 Reset asserted mid-FILL or mid-READ_WAIT SHALL abort the operation with no further ram_we pulse after release.

Structure
REQ-025 Opcode constants and state encoding SHALL reside in the shared instruction package used by all sequencer peripherals.
REQ-026 Position counter (row/col with wrap and address computation) SHALL be one sub-module, matrix_cursor.

Verification
REQ-027 LDR 3, LDC 5, WR 9 (128x128) -> one cycle later ram_addr=389, ram_data_i=9, ram_we=1 for one cycle; position (3,6).
REQ-028 LDR 127, LDC 127, WR 1 -> write at address 16383; position wraps to (0,0).
REQ-029 LDR 127, LDC 120, FILL 7 -> 8 consecutive ram_we pulses, addresses 16376..16383 data 7, busy=1 for 8 cycles, then busy=0, position (0,0).
REQ-030 LDR 2, LDC 0, RD with RAM model returning 4'hA -> out=8'h8A in READ_WAIT cycle with busy, then out=8'h0A; position (2,1).
REQ-031 WR issued during FILL, then opcode 9 in IDLE -> instruction dropped, out[6]=1 sticky; CLRERR -> out[6]=0.
REQ-032 Reset low during FILL at cell 10 -> all outputs 0 at once; after release no ram_we until a new WR/FILL.
